// File: rtl/sdram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_pkg : shared SDRAM command constants, widths and arbiter state type
// Revision  : 1.0
// ---------------------------------------------------------------------------
package sdram_pkg;

    localparam int BA_W   = 2;
    localparam int ADDR_W = 12;
    localparam int DQ_W   = 16;
    localparam int CMD_W  = 4;

    // Command word is {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP         = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PRECHARGE   = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AUTOREFRESH = 4'b0001;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_grant_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_grant_watchdog : bounds how long a grant may be held; sticky error
// Revision             : 1.0
// ---------------------------------------------------------------------------
module sdram_grant_watchdog #(
    parameter int MAX_GRANT_CYCLES = 2048
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_start,
    input  logic i_busy,
    input  logic i_done,
    output logic o_timeout,
    output logic o_timeout_err
);

    localparam int               CNT_W   = $clog2(MAX_GRANT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(MAX_GRANT_CYCLES - 1);

    logic [CNT_W-1:0] r_grant_cnt;
    logic             r_timeout_err;

    // An end pulse in the last allowed cycle takes precedence over the timeout
    assign o_timeout     = i_busy && !i_done && (r_grant_cnt == C_LIMIT);
    assign o_timeout_err = r_timeout_err;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_grant_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (i_start) begin
                r_grant_cnt <= '0;
            end else if (i_busy) begin
                r_grant_cnt <= r_grant_cnt + CNT_W'(1);
            end
            if (o_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_arbit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_arbit : fixed-priority grant of init/refresh/write/read onto SDRAM pins
// Revision    : 1.0
// ---------------------------------------------------------------------------
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int MAX_GRANT_CYCLES = 2048
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i_init_done,
    input  logic [CMD_W-1:0]  i_init_cmd,
    input  logic [BA_W-1:0]   i_init_ba,
    input  logic [ADDR_W-1:0] i_init_addr,
    input  logic              i_ar_req,
    input  logic              i_ar_end,
    input  logic [CMD_W-1:0]  i_ar_cmd,
    input  logic [BA_W-1:0]   i_ar_ba,
    input  logic [ADDR_W-1:0] i_ar_addr,
    input  logic              i_wr_req,
    input  logic              i_wr_end,
    input  logic [CMD_W-1:0]  i_wr_cmd,
    input  logic [BA_W-1:0]   i_wr_ba,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_wr_sdram_en,
    input  logic [DQ_W-1:0]   i_wr_sdram_data,
    input  logic              i_rd_req,
    input  logic              i_rd_end,
    input  logic [CMD_W-1:0]  i_rd_cmd,
    input  logic [BA_W-1:0]   i_rd_ba,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_ar_en,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic              o_sdram_cke,
    output logic              o_sdram_cs_n,
    output logic              o_sdram_ras_n,
    output logic              o_sdram_cas_n,
    output logic              o_sdram_we_n,
    output logic [BA_W-1:0]   o_sdram_ba,
    output logic [ADDR_W-1:0] o_sdram_addr,
    output logic [DQ_W-1:0]   o_sdram_dq_o,
    output logic              o_sdram_dq_oe,
    output logic              o_timeout_err
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_ar_en;
    logic              r_wr_en;
    logic              r_rd_en;
    logic              r_cke;
    logic              w_owner_end;
    logic              w_busy;
    logic              w_start;
    logic              w_timeout;
    logic [CMD_W-1:0]  w_cmd;
    logic [BA_W-1:0]   w_ba;
    logic [ADDR_W-1:0] w_addr;
    logic [DQ_W-1:0]   w_dq_o;
    logic              w_dq_oe;

    assign w_busy  = (r_state == ST_AREF) || (r_state == ST_WRITE) || (r_state == ST_READ);
    assign w_start = (r_state == ST_ARBIT) && (w_next_state != ST_ARBIT);

    sdram_grant_watchdog #(
        .MAX_GRANT_CYCLES (MAX_GRANT_CYCLES)
    ) u_watchdog (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .i_start       (w_start),
        .i_busy        (w_busy),
        .i_done        (w_owner_end),
        .o_timeout     (w_timeout),
        .o_timeout_err (o_timeout_err)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_INIT;
            r_ar_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_cke   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Grants only leave ARBIT, so these are one-cycle entry pulses
            r_ar_en <= (r_state == ST_ARBIT) && (w_next_state == ST_AREF);
            r_wr_en <= (r_state == ST_ARBIT) && (w_next_state == ST_WRITE);
            r_rd_en <= (r_state == ST_ARBIT) && (w_next_state == ST_READ);
            r_cke   <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_owner_end  = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (i_init_done) w_next_state = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (i_ar_req)      w_next_state = ST_AREF;
                else if (i_wr_req) w_next_state = ST_WRITE;
                else if (i_rd_req) w_next_state = ST_READ;
            end
            ST_AREF, ST_WRITE, ST_READ: begin
                w_owner_end = ((r_state == ST_AREF)  && i_ar_end) ||
                              ((r_state == ST_WRITE) && i_wr_end) ||
                              ((r_state == ST_READ)  && i_rd_end);
                if (w_owner_end || w_timeout) w_next_state = ST_ARBIT;
            end
            default: w_next_state = ST_INIT;
        endcase
    end

    always_comb begin
        w_cmd   = CMD_NOP;
        w_ba    = {BA_W{1'b1}};
        w_addr  = {ADDR_W{1'b1}};
        w_dq_o  = '0;
        w_dq_oe = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_cmd  = i_init_cmd;
                w_ba   = i_init_ba;
                w_addr = i_init_addr;
            end
            ST_AREF: begin
                w_cmd  = i_ar_cmd;
                w_ba   = i_ar_ba;
                w_addr = i_ar_addr;
            end
            ST_WRITE: begin
                w_cmd   = i_wr_cmd;
                w_ba    = i_wr_ba;
                w_addr  = i_wr_addr;
                w_dq_o  = i_wr_sdram_data;
                w_dq_oe = i_wr_sdram_en;
            end
            ST_READ: begin
                w_cmd  = i_rd_cmd;
                w_ba   = i_rd_ba;
                w_addr = i_rd_addr;
            end
            default: ;
        endcase
    end

    assign o_ar_en       = r_ar_en;
    assign o_wr_en       = r_wr_en;
    assign o_rd_en       = r_rd_en;
    assign o_sdram_cke   = r_cke;
    assign o_sdram_cs_n  = w_cmd[3];
    assign o_sdram_ras_n = w_cmd[2];
    assign o_sdram_cas_n = w_cmd[1];
    assign o_sdram_we_n  = w_cmd[0];
    assign o_sdram_ba    = w_ba;
    assign o_sdram_addr  = w_addr;
    assign o_sdram_dq_o  = w_dq_o;
    assign o_sdram_dq_oe = w_dq_oe;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sdram_arbit : owner/age reference model plus directed handshake vectors
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_sdram_arbit;

    localparam int MAXG = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        init_done = 1'b0;
    logic [3:0]  init_cmd = 4'b0111;
    logic [1:0]  init_ba = 2'b00;
    logic [11:0] init_addr = 12'h000;
    logic        ar_req = 1'b0, ar_end = 1'b0;
    logic [3:0]  ar_cmd = 4'b0111;
    logic [1:0]  ar_ba = 2'b10;
    logic [11:0] ar_addr = 12'h111;
    logic        wr_req = 1'b0, wr_end = 1'b0;
    logic [3:0]  wr_cmd = 4'b0100;
    logic [1:0]  wr_ba = 2'b01;
    logic [11:0] wr_addr = 12'h222;
    logic        wr_sdram_en = 1'b0;
    logic [15:0] wr_sdram_data = 16'h0000;
    logic        rd_req = 1'b0, rd_end = 1'b0;
    logic [3:0]  rd_cmd = 4'b0101;
    logic [1:0]  rd_ba = 2'b00;
    logic [11:0] rd_addr = 12'h333;

    logic        o_ar_en, o_wr_en, o_rd_en, o_sdram_cke;
    logic        o_cs_n, o_ras_n, o_cas_n, o_we_n;
    logic [1:0]  o_ba;
    logic [11:0] o_addr;
    logic [15:0] o_dq;
    logic        o_dq_oe, o_timeout_err;
    logic [3:0]  pins;
    logic [2:0]  ens;

    assign pins = {o_cs_n, o_ras_n, o_cas_n, o_we_n};
    assign ens  = {o_ar_en, o_wr_en, o_rd_en};

    sdram_arbit #(.MAX_GRANT_CYCLES(MAXG)) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .i_init_done     (init_done),
        .i_init_cmd      (init_cmd),
        .i_init_ba       (init_ba),
        .i_init_addr     (init_addr),
        .i_ar_req        (ar_req),
        .i_ar_end        (ar_end),
        .i_ar_cmd        (ar_cmd),
        .i_ar_ba         (ar_ba),
        .i_ar_addr       (ar_addr),
        .i_wr_req        (wr_req),
        .i_wr_end        (wr_end),
        .i_wr_cmd        (wr_cmd),
        .i_wr_ba         (wr_ba),
        .i_wr_addr       (wr_addr),
        .i_wr_sdram_en   (wr_sdram_en),
        .i_wr_sdram_data (wr_sdram_data),
        .i_rd_req        (rd_req),
        .i_rd_end        (rd_end),
        .i_rd_cmd        (rd_cmd),
        .i_rd_ba         (rd_ba),
        .i_rd_addr       (rd_addr),
        .o_ar_en         (o_ar_en),
        .o_wr_en         (o_wr_en),
        .o_rd_en         (o_rd_en),
        .o_sdram_cke     (o_sdram_cke),
        .o_sdram_cs_n    (o_cs_n),
        .o_sdram_ras_n   (o_ras_n),
        .o_sdram_cas_n   (o_cas_n),
        .o_sdram_we_n    (o_we_n),
        .o_sdram_ba      (o_ba),
        .o_sdram_addr    (o_addr),
        .o_sdram_dq_o    (o_dq),
        .o_sdram_dq_oe   (o_dq_oe),
        .o_timeout_err   (o_timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;
    int n_ar = 0, n_wr = 0, n_rd = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the pins (-1 init, 0 nobody, 1 refresh, 2 write, 3 read)
    // and how many cycles the current grant has already lasted.
    int m_owner = -1;
    int m_age   = 0;
    bit m_err   = 1'b0;
    bit m_cke   = 1'b0;

    function automatic bit owner_end(input int o);
        case (o)
            1:       return ar_end;
            2:       return wr_end;
            3:       return rd_end;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_owner = -1;
            m_age   = 0;
            m_err   = 1'b0;
            m_cke   = 1'b0;
        end else begin
            m_cke = 1'b1;
            if (m_owner < 0) begin
                if (init_done) m_owner = 0;
            end else if (m_owner == 0) begin
                m_age = 0;
                if (ar_req)      m_owner = 1;
                else if (wr_req) m_owner = 2;
                else if (rd_req) m_owner = 3;
            end else if (owner_end(m_owner)) begin
                m_owner = 0;
            end else if (m_age == MAXG - 1) begin
                m_owner = 0;
                m_err   = 1'b1;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge sys_clk) begin : compare
        logic [3:0]  e_cmd;
        logic [1:0]  e_ba;
        logic [11:0] e_addr;
        if (chk_on) begin
            case (m_owner)
                -1:      begin e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr; end
                1:       begin e_cmd = ar_cmd;   e_ba = ar_ba;   e_addr = ar_addr;   end
                2:       begin e_cmd = wr_cmd;   e_ba = wr_ba;   e_addr = wr_addr;   end
                3:       begin e_cmd = rd_cmd;   e_ba = rd_ba;   e_addr = rd_addr;   end
                default: begin e_cmd = 4'b0111;  e_ba = 2'b11;   e_addr = 12'hFFF;   end
            endcase
            chk("m_cmd",  pins,   e_cmd);
            chk("m_ba",   o_ba,   e_ba);
            chk("m_addr", o_addr, e_addr);
            chk("m_ens",  ens, {m_owner == 1 && m_age == 0,
                                m_owner == 2 && m_age == 0,
                                m_owner == 3 && m_age == 0});
            chk("m_dq_oe", o_dq_oe, (m_owner == 2) ? wr_sdram_en : 1'b0);
            chk("m_dq",    o_dq,    (m_owner == 2) ? wr_sdram_data : 16'h0000);
            chk("m_terr",  o_timeout_err, m_err);
            chk("m_cke",   o_sdram_cke,   m_cke);
            if (o_ar_en) n_ar++;
            if (o_wr_en) n_wr++;
            if (o_rd_en) n_rd++;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    initial begin : stim
        int steps;
        #1 sys_rst_n = 1'b0;
        #1 chk_on = 1'b1;
        init_cmd  = 4'b0010;
        init_ba   = 2'b01;
        init_addr = 12'h400;
        step();
        step();
        #1;
        chk("rst_cke",  o_sdram_cke, 1'b0);
        chk("rst_ens",  ens, 3'b000);
        chk("rst_terr", o_timeout_err, 1'b0);
        chk("rst_cmd",  pins, 4'b0010);
        sys_rst_n = 1'b1;

        // Init passthrough, then NOP/idle pins once init_done is seen
        step();
        #1;
        chk("init_cmd",  pins, 4'b0010);
        chk("init_addr", o_addr, 12'h400);
        chk("init_cke",  o_sdram_cke, 1'b1);
        init_done = 1'b1;
        step();
        #1;
        chk("arbit_cmd",  pins, 4'b0111);
        chk("arbit_ba",   o_ba, 2'b11);
        chk("arbit_addr", o_addr, 12'hFFF);
        init_done = 1'b0;
        step();
        #1;
        chk("init_done_drop", pins, 4'b0111);

        // Refresh handshake
        ar_req = 1'b1;
        step();
        ar_req = 1'b0;
        ar_cmd = 4'b0010;
        #1;
        chk("aref_en",  o_ar_en, 1'b1);
        chk("aref_pre", pins, 4'b0010);
        step();
        ar_cmd = 4'b0001;
        #1;
        chk("aref_en_once", o_ar_en, 1'b0);
        chk("aref_ref",     pins, 4'b0001);
        ar_end = 1'b1;
        step();
        ar_end = 1'b0;
        ar_cmd = 4'b0111;
        #1;
        chk("aref_back", pins, 4'b0111);
        step();
        #1;
        chk("aref_no_second", n_ar, 1);

        // All three requests together, plus DQ gating in WRITE vs READ
        wr_sdram_en   = 1'b1;
        wr_sdram_data = 16'hA5A5;
        ar_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        step();
        ar_req = 1'b0;
        #1;
        chk("prio_first_ar", ens, 3'b100);
        ar_end = 1'b1;
        step();
        ar_end = 1'b0;
        #1;
        chk("prio_gap1", ens, 3'b000);
        step();
        wr_req = 1'b0;
        #1;
        chk("prio_second_wr", ens, 3'b010);
        chk("dq_oe_write", o_dq_oe, 1'b1);
        chk("dq_write", o_dq, 16'hA5A5);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        #1;
        chk("prio_gap2", ens, 3'b000);
        step();
        rd_req = 1'b0;
        #1;
        chk("prio_third_rd", ens, 3'b001);
        chk("dq_oe_read", o_dq_oe, 1'b0);
        chk("dq_read", o_dq, 16'h0000);
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        #1;
        chk("prio_cnt_ar", n_ar, 2);
        chk("prio_cnt_wr", n_wr, 1);
        chk("prio_cnt_rd", n_rd, 1);

        // Request mid-WRITE with a stray non-owner end
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        step();
        ar_req = 1'b1;
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        #1;
        chk("mid_wr_hold", pins, 4'b0100);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        #1;
        chk("mid_wr_arbit", pins, 4'b0111);
        chk("mid_wr_no_ar", o_ar_en, 1'b0);
        step();
        ar_req = 1'b0;
        #1;
        chk("mid_wr_ar_grant", o_ar_en, 1'b1);
        ar_end = 1'b1;
        step();
        ar_end = 1'b0;

        // Watchdog: read grant with no end pulse
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        #1;
        chk("wd_rd_en", o_rd_en, 1'b1);
        steps = 0;
        while (steps < 40) begin
            step();
            steps++;
            #1;
            if (pins == 4'b0111) break;
        end
        chk("wd_cycles", steps, MAXG);
        chk("wd_terr", o_timeout_err, 1'b1);
        step();
        step();
        #1;
        chk("wd_terr_sticky", o_timeout_err, 1'b1);

        // Reset in the middle of a write grant
        init_done = 1'b1;
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
        step();
        sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_cmd",  pins, 4'b0010);
        chk("rst_mid_terr", o_timeout_err, 1'b0);
        chk("rst_mid_ens",  ens, 3'b000);
        chk("rst_mid_oe",   o_dq_oe, 1'b0);
        step();
        sys_rst_n = 1'b1;
        step();
        step();
        #1;
        chk("rst_recover", pins, 4'b0111);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_arbit.md
# sdram_arbit

SDRAM command arbiter: the responder side of the per-function request/enable handshake. It sits between the init, auto-refresh, write and read sub-controllers and the SDRAM pins. It grants one requester at a time with fixed priority, and multiplexes that requester's command, bank, address and DQ drive onto the device. A grant watchdog recovers from a sub-controller that never signals end.

## Interface
- `MAX_GRANT_CYCLES`, default 2048: maximum cycles a grant may be held before forced release.
- `sys_clk`  in  1  system clock, 100 MHz.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `init_done`  in  1  initialization complete; level signal that stays high once set.
- `init_cmd`, `init_ba`, `init_addr`  in  4/2/12  init command, bank and address.
- `ar_req`  in  1  auto-refresh request.
- `ar_end`  in  1  auto-refresh end pulse.
- `ar_cmd`, `ar_ba`, `ar_addr`  in  4/2/12  auto-refresh command, bank and address.
- `wr_req`, `wr_end`  in  1  write request and write end pulse.
- `wr_cmd`, `wr_ba`, `wr_addr`  in  4/2/12  write command, bank and address.
- `wr_sdram_en`  in  1  write data drive enable.
- `wr_sdram_data`  in  16  write data.
- `rd_req`, `rd_end`  in  1  read request and read end pulse.
- `rd_cmd`, `rd_ba`, `rd_addr`  in  4/2/12  read command, bank and address.
- `ar_en`, `wr_en`, `rd_en`  out  1  single-cycle grant pulses.
- `sdram_cke`  out  1  clock enable.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n`  out  1  command pins, = selected `cmd[3:0]`.
- `sdram_ba`  out  2  bank.
- `sdram_addr`  out  12  address.
- `sdram_dq_o`  out  16  DQ output data.
- `sdram_dq_oe`  out  1  DQ output enable.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- Command encoding is {cs_n, ras_n, cas_n, we_n}: NOP=0111, PRECHARGE=0010, AUTOREFRESH=0001.
- States: INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- **INIT:** pins follow the `init_*` inputs. Go to ARBIT when `init_done` is 1.
- **ARBIT:** pins show NOP, bank 2'b11 and address 12'hFFF. Priority is `ar_req` > `wr_req` > `rd_req`:
  - `ar_req` wins → go to AREF.
  - else `wr_req` → go to WRITE.
  - else `rd_req` → go to READ.
  - else stay in ARBIT.
- **Grant pulses:** `ar_en`, `wr_en` and `rd_en` are registered. Each is 1 for exactly the first cycle of the granted state and 0 at all other times. A level grant is forbidden because it would re-trigger a sub-controller that has returned to IDLE before its end pulse is seen.
- **AREF, WRITE, READ:**
  - Pins follow the owner's `cmd`/`ba`/`addr`.
  - The state returns to ARBIT on the owner's `*_end`.
  - `*_end` pulses from non-owners are ignored.
- **DQ drive:** `sdram_dq_oe` = `wr_sdram_en` in WRITE only, else 0. `sdram_dq_o` = `wr_sdram_data` in WRITE, else 0.
- **Preemption:** none. A request raised during another grant is not dropped; it is served at the next ARBIT, because requesters hold `*_req` until acknowledged.
- **Watchdog:**
  - `grant_cnt` has width $clog2(MAX_GRANT_CYCLES+1). It clears on entry to any grant state and increments each grant cycle.
  - If it reaches MAX_GRANT_CYCLES-1 without the owner's end, the next state is ARBIT and `timeout_err` is set.
  - `timeout_err` clears only on reset.
- `sdram_cke` = 1 whenever not in reset.
- **Reset values:**
  - State INIT.
  - All `*_en` = 0.
  - `grant_cnt` = 0.
  - `timeout_err` = 0.
  - `sdram_cke` = 0 during reset.

## Timing
- Pin mux is combinational from the registered state, so no added latency to sub-controller commands.
- Grant latency: `*_req` seen high in ARBIT at cycle N → state = granted and `*_en` = 1 at N+1.
- End to ARBIT: `*_end` high at cycle N → ARBIT at N+1. The earliest next grant is at N+2, so there is a minimum of one ARBIT cycle between grants.
- Simultaneous `*_end` and a new request: the request waits one ARBIT cycle and is not lost.
- Simultaneous `ar_req` and `wr_req` in ARBIT: AREF is chosen; the write waits.
- `init_done` deasserting after INIT is ignored.
- Reset mid-grant: state returns to INIT immediately, pins return to `init_*`, and the enables drop.

## Structure
- Shared package `sdram_pkg` holds:
  - command constants CMD_NOP, CMD_PRECHARGE, CMD_AUTOREFRESH;
  - the arbiter state enum;
  - width constants BA_W=2, ADDR_W=12, DQ_W=16.
- The auto-refresh block adopts the same package constants.
- One sub-module is natural: `sdram_grant_watchdog`, which wraps the counter and the sticky flag. It takes a start pulse, busy level and done pulse, and outputs a timeout pulse.
- The FSM and pin mux live in `sdram_arbit`.

## Test plan
- **Init passthrough:** reset, drive `init_cmd`=0010 with `init_done`=0 → pins show 0010. Raise `init_done` → NOP at the next cycle, state ARBIT.
- **Refresh handshake:** `ar_req`=1 in ARBIT →
  - `ar_en` high for exactly 1 cycle;
  - `ar_cmd` 0010 then 0001 appears on the pins;
  - `ar_end` pulse → ARBIT one cycle later, with no second `ar_en`.
- **Priority:** `ar_req`, `wr_req` and `rd_req` all rise together →
  - grant order AREF, WRITE, READ;
  - each grant separated by at least 1 ARBIT cycle;
  - exactly one `*_en` pulse per grant.
- **Request during grant:** `ar_req` rises mid-WRITE → WRITE completes untouched; AREF is granted 2 cycles after `wr_end`.
- **DQ gating:** in WRITE with `wr_sdram_en`=1 and `wr_sdram_data`=16'hA5A5 → `sdram_dq_oe`=1 and `sdram_dq_o`=A5A5. In READ the same inputs give `sdram_dq_oe`=0.
- **Watchdog and reset:**
  - With MAX_GRANT_CYCLES=16, grant `rd_req` and never pulse `rd_end` → ARBIT after 16 cycles and `timeout_err`=1 stays set.
  - Assert `sys_rst_n`=0 mid-grant → INIT, `timeout_err`=0, all enables 0.
